// File: rtl/pomo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pomo_pkg
// Purpose  : Shared types and constants for the pomodoro countdown datapath:
//            the countdown state encoding, BCD digit width, reset defaults
//            and the digit clamp helper used when a load value arrives.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pomo_pkg;

  localparam int BCD_DIGIT_W = 4;

  // Value shown after reset and held in the reload shadow until first load.
  localparam logic [7:0] DEF_MIN = 8'h25;
  localparam logic [7:0] DEF_SEC = 8'h00;

  // Largest legal seconds-tens digit and largest legal decimal digit.
  localparam logic [BCD_DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Saturate a BCD digit to an upper bound.
  function automatic logic [BCD_DIGIT_W-1:0] clamp_digit(
    input logic [BCD_DIGIT_W-1:0] d,
    input logic [BCD_DIGIT_W-1:0] max
  );
    return (d > max) ? max : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Modulo-N counter with enable and synchronous clear. Raises a
//            one-cycle terminal pulse in the cycle the count equals N-1
//            while enabled; the count then wraps to 0.
// Ports    : clk   - system clock
//            rst_n - asynchronous active-low reset (count -> 0)
//            en    - advance the count this cycle
//            clr   - synchronous clear, wins over en
//            pulse - terminal pulse (combinational from the count)
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic pulse
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign pulse = en && !clr && (r_count == LAST);

endmodule
`default_nettype wire

// File: rtl/bcd_countdown.sv
`default_nettype none
// ============================================================================
// Module   : bcd_countdown
// Purpose  : MM:SS BCD countdown for the pomodoro timer. Loads a clamped
//            start value, counts down once per second while running, flags
//            expiry with a one-cycle pulse and blinks the display afterwards.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            load       - pulse: load load_min/load_sec, go IDLE
//            load_min   - BCD minutes {tens, units}
//            load_sec   - BCD seconds {tens, units}
//            toggle     - pulse: start / pause / resume
//            clear      - pulse: reload last loaded value, go IDLE
//            min_bcd    - current minutes (BCD)
//            sec_bcd    - current seconds (BCD)
//            running    - high while counting
//            done_pulse - one-cycle expiry pulse, aligned with 00:00
//            blink      - display blank request while expired
// Revision : 1.0 - initial release
// ============================================================================
module bcd_countdown #(
  parameter int TICK_DIV  = 100000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       toggle,
  input  logic       clear,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done_pulse,
  output logic       blink
);

  import pomo_pkg::*;

  state_t r_state;
  logic [7:0] r_shadow_min;
  logic [7:0] r_shadow_sec;

  logic w_tick;
  logic w_blink_tick;

  // ---------------------------------------------------------------------------
  // Dividers. The prescaler only advances in RUN when no higher-priority
  // pulse is present, so a pause holds its count and a resume continues it.
  // ---------------------------------------------------------------------------
  logic w_pre_en;
  logic w_pre_clr;
  logic w_blink_en;
  logic w_blink_clr;

  assign w_pre_en    = (r_state == RUN) && !load && !clear && !toggle;
  assign w_pre_clr   = load || clear || (toggle && (r_state == IDLE));
  // Blink divider sits at 0 outside EXPIRED so each expiry starts a fresh phase.
  assign w_blink_en  = (r_state == EXPIRED) && !load && !clear;
  assign w_blink_clr = (r_state != EXPIRED) || load || clear;

  tick_gen #(.N(TICK_DIV)) u_sec_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_pre_en),
    .clr   (w_pre_clr),
    .pulse (w_tick)
  );

  tick_gen #(.N(BLINK_DIV)) u_blink_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_blink_en),
    .clr   (w_blink_clr),
    .pulse (w_blink_tick)
  );

  // ---------------------------------------------------------------------------
  // Load clamping: out-of-range digits saturate to the largest legal digit.
  // ---------------------------------------------------------------------------
  logic [7:0] w_ld_min;
  logic [7:0] w_ld_sec;

  assign w_ld_min = {clamp_digit(load_min[7:4], DIGIT_MAX),
                     clamp_digit(load_min[3:0], DIGIT_MAX)};
  assign w_ld_sec = {clamp_digit(load_sec[7:4], SEC_TENS_MAX),
                     clamp_digit(load_sec[3:0], DIGIT_MAX)};

  // ---------------------------------------------------------------------------
  // Borrow-chain decrement. 00:00 is held so minutes tens never underflows.
  // ---------------------------------------------------------------------------
  logic [BCD_DIGIT_W-1:0] w_sec_u;
  logic [BCD_DIGIT_W-1:0] w_sec_t;
  logic [BCD_DIGIT_W-1:0] w_min_u;
  logic [BCD_DIGIT_W-1:0] w_min_t;
  logic                   w_count_zero;
  logic                   w_dec_zero;

  assign w_count_zero = ({min_bcd, sec_bcd} == 16'h0000);

  always_comb begin
    w_sec_u = sec_bcd[3:0];
    w_sec_t = sec_bcd[7:4];
    w_min_u = min_bcd[3:0];
    w_min_t = min_bcd[7:4];
    if (!w_count_zero) begin
      if (w_sec_u != 4'd0) begin
        w_sec_u = w_sec_u - 4'd1;
      end else begin
        w_sec_u = DIGIT_MAX;
        if (w_sec_t != 4'd0) begin
          w_sec_t = w_sec_t - 4'd1;
        end else begin
          w_sec_t = SEC_TENS_MAX;
          if (w_min_u != 4'd0) begin
            w_min_u = w_min_u - 4'd1;
          end else begin
            w_min_u = DIGIT_MAX;
            if (w_min_t != 4'd0) begin
              w_min_t = w_min_t - 4'd1;
            end
          end
        end
      end
    end
  end

  assign w_dec_zero = ({w_min_t, w_min_u, w_sec_t, w_sec_u} == 16'h0000);

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs. Priority: load > clear > toggle > tick.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      min_bcd      <= DEF_MIN;
      sec_bcd      <= DEF_SEC;
      r_shadow_min <= DEF_MIN;
      r_shadow_sec <= DEF_SEC;
      running      <= 1'b0;
      done_pulse   <= 1'b0;
      blink        <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (load) begin
        min_bcd      <= w_ld_min;
        sec_bcd      <= w_ld_sec;
        r_shadow_min <= w_ld_min;
        r_shadow_sec <= w_ld_sec;
        r_state      <= IDLE;
        running      <= 1'b0;
        blink        <= 1'b0;
      end else if (clear) begin
        min_bcd <= r_shadow_min;
        sec_bcd <= r_shadow_sec;
        r_state <= IDLE;
        running <= 1'b0;
        blink   <= 1'b0;
      end else if (toggle && (r_state != EXPIRED)) begin
        if ((r_state != RUN) && w_count_zero) begin
          // Starting from 00:00 expires at once rather than waiting a tick.
          r_state    <= EXPIRED;
          running    <= 1'b0;
          done_pulse <= 1'b1;
          blink      <= 1'b0;
        end else if (r_state == RUN) begin
          r_state <= PAUSED;
          running <= 1'b0;
        end else begin
          r_state <= RUN;
          running <= 1'b1;
        end
      end else if ((r_state == RUN) && w_tick) begin
        min_bcd <= {w_min_t, w_min_u};
        sec_bcd <= {w_sec_t, w_sec_u};
        if (w_dec_zero) begin
          r_state    <= EXPIRED;
          running    <= 1'b0;
          done_pulse <= 1'b1;
          blink      <= 1'b0;
        end
      end else if ((r_state == EXPIRED) && w_blink_tick) begin
        blink <= ~blink;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_countdown
// Purpose  : Self-checking bench for bcd_countdown (TICK_DIV=4, BLINK_DIV=2).
//            Reference model keeps the count as plain total seconds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown;

  localparam int TICK  = 4;
  localparam int BLNK  = 2;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       toggle;
  logic       clear;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done_pulse;
  logic       blink;

  bcd_countdown #(.TICK_DIV(TICK), .BLINK_DIV(BLNK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .toggle     (toggle),
    .clear      (clear),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .running    (running),
    .done_pulse (done_pulse),
    .blink      (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 0=idle 1=run 2=paused 3=expired
  int m_state, m_secs, m_shadow, m_phase, m_expc, m_done;

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int bcd_to_secs(input logic [7:0] lm, input logic [7:0] ls);
    int mt, mu, st, su;
    mt = sat(int'(lm[7:4]), 9);
    mu = sat(int'(lm[3:0]), 9);
    st = sat(int'(ls[7:4]), 5);
    su = sat(int'(ls[3:0]), 9);
    return (mt * 10 + mu) * 60 + st * 10 + su;
  endfunction

  task automatic model_reset();
    m_state = 0; m_secs = 25 * 60; m_shadow = 25 * 60;
    m_phase = 0; m_expc = 0; m_done = 0;
  endtask

  task automatic model_expire();
    m_state = 3; m_done = 1; m_expc = 0;
  endtask

  task automatic model_step(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                            input logic tg, input logic cl);
    m_done = 0;
    if (ld) begin
      m_secs = bcd_to_secs(lm, ls); m_shadow = m_secs; m_state = 0; m_phase = 0;
    end else if (cl) begin
      m_secs = m_shadow; m_state = 0; m_phase = 0;
    end else if (tg && m_state != 3) begin
      if (m_state != 1 && m_secs == 0) model_expire();
      else if (m_state == 0) begin m_state = 1; m_phase = 0; end
      else if (m_state == 1) m_state = 2;
      else m_state = 1;
    end else if (m_state == 1) begin
      if (m_phase == TICK - 1) begin
        m_phase = 0;
        m_secs  = m_secs - 1;
        if (m_secs == 0) model_expire();
      end else begin
        m_phase = m_phase + 1;
      end
    end else if (m_state == 3) begin
      m_expc = m_expc + 1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".min"},     int'(min_bcd),    to_bcd(m_secs / 60));
    chk({tag, ".sec"},     int'(sec_bcd),    to_bcd(m_secs % 60));
    chk({tag, ".running"}, int'(running),    (m_state == 1) ? 1 : 0);
    chk({tag, ".done"},    int'(done_pulse), m_done);
    chk({tag, ".blink"},   int'(blink),      (m_state == 3) ? ((m_expc / BLNK) % 2) : 0);
  endtask

  // Drive one cycle of inputs from a negedge, update model at the posedge,
  // compare at the following negedge.
  task automatic step(input string tag, input logic ld, input logic [7:0] lm,
                      input logic [7:0] ls, input logic tg, input logic cl);
    load = ld; load_min = lm; load_sec = ls; toggle = tg; clear = cl;
    @(posedge clk);
    model_step(ld, lm, ls, tg, cl);
    @(negedge clk);
    check_model(tag);
    load = 1'b0; toggle = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_load(input string tag, input logic [7:0] lm, input logic [7:0] ls);
    step(tag, 1'b1, lm, ls, 1'b0, 1'b0);
  endtask

  task automatic do_toggle(input string tag);
    step(tag, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic [7:0] lm;
    logic [7:0] ls;
    logic [7:0] em;
    logic [7:0] es;
  } load_vec_t;

  load_vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h00, 8'h12, 8'h00, 8'h12};
    vecs[1] = '{8'hAF, 8'h7C, 8'h99, 8'h59};
    vecs[2] = '{8'h99, 8'h59, 8'h99, 8'h59};
    vecs[3] = '{8'h5A, 8'h6B, 8'h59, 8'h59};
    vecs[4] = '{8'hA0, 8'hF0, 8'h90, 8'h50};
    vecs[5] = '{8'h0F, 8'h09, 8'h09, 8'h09};
    vecs[6] = '{8'h12, 8'h34, 8'h12, 8'h34};

    rst_n = 1'b0; load = 1'b0; load_min = 8'h00; load_sec = 8'h00;
    toggle = 1'b0; clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and 20 idle cycles
    idle("reset_idle", 20);
    chk("reset.min", int'(min_bcd), 'h25);
    chk("reset.sec", int'(sec_bcd), 'h00);

    // Load clamp table
    foreach (vecs[i]) begin
      do_load("load_tbl", vecs[i].lm, vecs[i].ls);
      chk("load_tbl.min", int'(min_bcd), int'(vecs[i].em));
      chk("load_tbl.sec", int'(sec_bcd), int'(vecs[i].es));
    end

    // 00:12 countdown to expiry, then blink
    do_load("cd12", 8'h00, 8'h12);
    do_toggle("cd12");
    chk("cd12.running", int'(running), 1);
    for (int v = 11; v >= 0; v--) begin
      idle("cd12", 3);
      chk("cd12.hold", int'(sec_bcd), to_bcd(v + 1));
      idle("cd12", 1);
      chk("cd12.step", int'(sec_bcd), to_bcd(v));
    end
    chk("cd12.done", int'(done_pulse), 1);
    chk("cd12.min0", int'(min_bcd), 0);
    idle("cd12_exp", 1);
    chk("cd12.done_once", int'(done_pulse), 0);
    chk("cd12.blink_e1", int'(blink), 0);
    idle("cd12_exp", 1);
    chk("cd12.blink_e2", int'(blink), 1);
    idle("cd12_exp", 2);
    chk("cd12.blink_e4", int'(blink), 0);
    do_toggle("cd12_exp_tog");
    chk("cd12.tog_ignored", int'(running), 0);

    // Borrow cases
    do_load("b100", 8'h01, 8'h00);
    do_toggle("b100");
    idle("b100", 4);
    chk("b100.min", int'(min_bcd), 'h00);
    chk("b100.sec", int'(sec_bcd), 'h59);
    do_load("b1000", 8'h10, 8'h00);
    do_toggle("b1000");
    idle("b1000", 4);
    chk("b1000.min", int'(min_bcd), 'h09);
    chk("b1000.sec", int'(sec_bcd), 'h59);

    // Pause keeps the prescaler phase
    do_load("pause", 8'h00, 8'h05);
    do_toggle("pause");
    idle("pause", 2);
    do_toggle("pause");
    chk("pause.running", int'(running), 0);
    for (int i = 0; i < 10; i++) begin
      idle("pause_hold", 1);
      chk("pause.hold", int'(sec_bcd), 'h05);
    end
    do_toggle("pause_resume");
    idle("pause_resume", 1);
    chk("resume.c1", int'(sec_bcd), 'h05);
    idle("pause_resume", 1);
    chk("resume.c2", int'(sec_bcd), 'h04);

    // load and toggle together while running
    do_load("ldtog", 8'h00, 8'h40);
    do_toggle("ldtog");
    idle("ldtog", 5);
    step("ldtog", 1'b1, 8'h42, 8'h17, 1'b1, 1'b0);
    chk("ldtog.min", int'(min_bcd), 'h42);
    chk("ldtog.sec", int'(sec_bcd), 'h17);
    chk("ldtog.running", int'(running), 0);
    idle("ldtog_idle", 6);
    chk("ldtog.held", int'(sec_bcd), 'h17);

    // clear while expired
    do_load("clr", 8'h00, 8'h03);
    do_toggle("clr");
    idle("clr", 12);
    chk("clr.expired", int'(done_pulse), 1);
    idle("clr", 3);
    step("clr", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("clr.sec", int'(sec_bcd), 'h03);
    chk("clr.blink", int'(blink), 0);
    idle("clr_idle", 5);
    chk("clr.idle", int'(sec_bcd), 'h03);

    // toggle at 00:00 expires immediately
    do_load("zero", 8'h00, 8'h00);
    do_toggle("zero");
    chk("zero.done", int'(done_pulse), 1);
    idle("zero", 1);
    chk("zero.done_once", int'(done_pulse), 0);

    // asynchronous reset mid-run
    do_load("arst", 8'h00, 8'h30);
    do_toggle("arst");
    idle("arst", 5);
    rst_n = 1'b0;
    #1;
    chk("arst.min", int'(min_bcd), 'h25);
    chk("arst.sec", int'(sec_bcd), 'h00);
    chk("arst.running", int'(running), 0);
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    idle("arst_after", 3);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic       ld, tg, cl;
      logic [7:0] lm, ls;
      ld = ($urandom_range(0, 99) < 2);
      cl = ($urandom_range(0, 99) < 2);
      tg = ($urandom_range(0, 99) < 6);
      lm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ls = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
      step("rand", ld, lm, ls, tg, cl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
- MM:SS countdown datapath for the pomodoro timer. It holds a BCD minutes/seconds value, decrements it once per second while running, and flags expiry.
- It sits between the debounced lever/button pulses and the seven_seg_disp input.
- Outputs min_bcd/sec_bcd feed the display bus {min_bcd, sec_bcd}. The blink output drives the display-blank gate.

Parameters:
- TICK_DIV, 100000000: clk cycles per one-second tick. Simulation uses 4.
- BLINK_DIV, 25000000: clk cycles per blink toggle while expired (2 Hz blink).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  single-cycle pulse; loads load_min/load_sec and returns to IDLE.
- load_min  in  8  BCD minutes {tens, units}.
- load_sec  in  8  BCD seconds {tens, units}.
- toggle  in  1  single-cycle pulse (debounced lever); start/resume/pause.
- clear  in  1  single-cycle pulse (debounced button); reload last loaded value and go to IDLE.
- min_bcd  out  8  current minutes, BCD.
- sec_bcd  out  8  current seconds, BCD.
- running  out  1  high in RUN.
- done_pulse  out  1  one-cycle pulse on expiry.
- blink  out  1  display blank request: toggles every BLINK_DIV cycles in EXPIRED, else 0.

Behaviour:
- Reset (async assert): state=IDLE; min_bcd=8'h25; sec_bcd=8'h00; shadow reload register=25:00; running=0; done_pulse=0; blink=0; prescaler=0; blink counter=0.
- States and transitions:
  - IDLE: on toggle, go to RUN; prescaler cleared.
  - RUN: on toggle, go to PAUSED; prescaler held, not cleared.
  - PAUSED: on toggle, return to RUN; prescaler resumes from its held count.
  - EXPIRED: toggle is ignored; only load, clear or reset leave it.
- Priority in one cycle: load > clear > toggle > tick.
- load (any state): the clamped load value goes to both the count and the shadow register. Clamp rules:
  - a units digit >9 becomes 9;
  - a seconds-tens digit >5 becomes 5;
  - a minutes-tens digit >9 becomes 9.
  - After loading: state=IDLE, prescaler=0, blink=0. Visible on outputs the next cycle.
- clear: count=shadow, state=IDLE, prescaler=0, blink=0.
- Tick: in RUN the prescaler counts 0..TICK_DIV-1. The tick fires in the cycle the prescaler equals TICK_DIV-1, and the prescaler then wraps to 0.
- Decrement on tick. All outputs are registered; the new value appears 1 cycle after the tick cycle.
  - sec units 0 -> 9 with borrow; otherwise -1.
  - sec tens 0 -> 5 with borrow into minutes.
  - min units 0 -> 9 with borrow into min tens.
  - min tens is never decremented below 0.
- Expiry:
  - If a decrement produces 00:00, then in the same update state=EXPIRED and done_pulse=1 for exactly one cycle, aligned with the 00:00 output.
  - If toggle arrives in IDLE or PAUSED while the count is 00:00, go directly to EXPIRED with done_pulse the next cycle; no tick wait.
- EXPIRED behaviour:
  - Count held at 00:00.
  - Blink counter runs; blink toggles every BLINK_DIV cycles, starting from 0 on entry.
  - running=0.
- running = (state==RUN), registered.
- Max count 99:59; no upward counting.

Decomposition:
- Package pomo_pkg holds:
  - state enum {IDLE, RUN, PAUSED, EXPIRED};
  - BCD_DIGIT_W=4;
  - reset-default constants DEF_MIN=8'h25, DEF_SEC=8'h00;
  - seconds-tens max value 5.
- One sub-module, tick_gen: a parameterised modulo-N counter with enable, sync clear and a one-cycle terminal pulse.
- bcd_countdown instantiates tick_gen twice, once as the 1 Hz prescaler and once as the blink divider.
- Borrow-chain decrement stays in bcd_countdown as combinational logic.

Test Plan (TICK_DIV=4, BLINK_DIV=2):
- Reset then idle 20 cycles -> min_bcd=8'h25, sec_bcd=8'h00, running=0, done_pulse never asserted.
- load 00:12, toggle -> 1 cycle later running=1; sec_bcd steps 12,11,10,09 at 4-cycle intervals; 00:00 appears with done_pulse=1 for one cycle; then blink toggles every 2 cycles.
- load 01:00, toggle -> after first tick outputs 00:59. load 10:00 and tick -> 09:59 (double borrow).
- load 00:05, toggle, 2 cycles, toggle (pause) for 10 cycles, toggle -> first decrement occurs 2 cycles after resume (prescaler retained); value held at 05 during pause.
- load 8'hAF/8'h7C (invalid) -> outputs 99:59 (tens clamps to 9 for minutes, 5 for seconds; units clamp to 9).
- load and toggle in the same cycle while RUN -> state IDLE, loaded value shown, running=0. Clear while EXPIRED after load 00:03 -> 00:03, blink=0, IDLE. Async rst_n low mid-RUN -> 25:00 immediately.
